square_power_sched: RTL

//  Shares one pipelined signed_8b_square unit among NCHAN sample requesters.
//  A round-robin arbiter takes at most one signed 8b sample per clock into the squarer.
//  A tag pipeline tracks each in-flight square so the result is added to the right channel.

---
 rtl/square_power_sched.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/square_power_sched.sv
// Round-robin scheduler sharing one pipelined 8b squarer among NCHAN channels,
// accumulating ACC_LEN squares per channel into power words.
module square_power_sched #(
  parameter int unsigned NCHAN      = 4,
  parameter int unsigned SQ_LATENCY = 2,
  parameter int unsigned ACC_LEN    = 256,
  parameter int unsigned ACC_W      = 24
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  logic [NCHAN-1:0]         req_valid_i,
  input  logic [8*NCHAN-1:0]       req_data_i,
  output logic [NCHAN-1:0]         req_ready_o,
  output logic [7:0]               sq_in_o,
  input  logic [14:0]              sq_out_i,
  output logic                     pwr_valid_o,
  output logic [$clog2(NCHAN)-1:0] pwr_chan_o,
  output logic [ACC_W-1:0]         pwr_o,
  output logic                     busy_o
);

  localparam int unsigned CHW   = $clog2(NCHAN);
  localparam int unsigned CNT_W = $clog2(ACC_LEN);
  localparam int unsigned FLC_W = $clog2(SQ_LATENCY + 1);
  localparam int unsigned SQ_W  = 15;

  if (ACC_W < SQ_W + CNT_W) begin : g_acc_w_check
    $error("square_power_sched: ACC_W too narrow for ACC_LEN squares");
  end
  if ((NCHAN < 2) || (NCHAN > 16)) begin : g_nchan_check
    $error("square_power_sched: NCHAN must be 2..16");
  end
  if ((ACC_LEN < 2) || ((ACC_LEN & (ACC_LEN - 1)) != 0)) begin : g_acc_len_check
    $error("square_power_sched: ACC_LEN must be a power of 2, >= 2");
  end
  if (SQ_LATENCY < 1) begin : g_lat_check
    $error("square_power_sched: SQ_LATENCY must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [FLC_W-1:0]    flush_cnt;
  logic [CHW-1:0]      rr_ptr;
  logic [CHW-1:0]      cand_c;
  logic [CHW-1:0]      win_c;
  logic                found_c;
  logic                run_en_c;
  logic                xfer_c;
  logic [NCHAN-1:0]    grant_c;
  logic [7:0]          data_c;
  logic [SQ_LATENCY:0] tag_v;
  logic [SQ_LATENCY:0] tag_v_nxt;
  logic [CHW-1:0]      tag_ch [SQ_LATENCY+1];
  logic [ACC_W-1:0]    acc    [NCHAN];
  logic [CNT_W-1:0]    cnt    [NCHAN];
  logic [CHW-1:0]      ret_ch_c;
  logic [ACC_W-1:0]    acc_sum_c;

  // Round-robin search starting one past the last winner
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    cand_c  = '0;
    grant_c = '0;
    data_c  = '0;
    for (int unsigned k = 1; k <= NCHAN; k++) begin
      cand_c = CHW'((32'(rr_ptr) + k) % NCHAN);
      if (!found_c && req_valid_i[cand_c]) begin
        found_c = 1'b1;
        win_c   = cand_c;
      end
    end
    for (int unsigned i = 0; i < NCHAN; i++) begin
      if (win_c == CHW'(i)) begin
        data_c = req_data_i[8*i +: 8];
      end
    end
    grant_c[win_c] = found_c;
  end

  // Dropping enable_i withdraws grants in the same clock
  assign run_en_c    = (state == RUN) && enable_i;
  assign req_ready_o = run_en_c ? grant_c : '0;
  assign xfer_c      = run_en_c && found_c;

  assign tag_v_nxt = {tag_v[SQ_LATENCY-1:0], xfer_c} & {(SQ_LATENCY+1){~clear_i}};
  assign ret_ch_c  = tag_ch[SQ_LATENCY];
  assign acc_sum_c = acc[ret_ch_c] + ACC_W'(sq_out_i);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FLUSH leaves only after SQ_LATENCY+1 clocks and an empty tag pipe
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable_i) state_nxt = RUN;
      end
      RUN: begin
        if (!enable_i) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (enable_i) begin
          state_nxt = RUN;
        end else if ((flush_cnt == FLC_W'(SQ_LATENCY)) && !(|tag_v)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Squarer operand, tag pipe, arbitration pointer and status
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sq_in_o   <= '0;
      tag_v     <= '0;
      rr_ptr    <= CHW'(NCHAN - 1);
      flush_cnt <= '0;
      busy_o    <= 1'b0;
      for (int unsigned k = 0; k <= SQ_LATENCY; k++) begin
        tag_ch[k] <= '0;
      end
    end else begin
      sq_in_o   <= xfer_c ? data_c : 8'd0;
      tag_v     <= tag_v_nxt;
      tag_ch[0] <= win_c;
      for (int unsigned k = 1; k <= SQ_LATENCY; k++) begin
        tag_ch[k] <= tag_ch[k-1];
      end
      if (xfer_c) begin
        rr_ptr <= win_c;
      end
      if (state == FLUSH) begin
        if (flush_cnt != FLC_W'(SQ_LATENCY)) begin
          flush_cnt <= flush_cnt + 1'b1;
        end
      end else begin
        flush_cnt <= '0;
      end
      busy_o <= (state_nxt != IDLE) || (|tag_v_nxt);
    end
  end

  // Per-channel accumulation; clear_i wins over a retiring square
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pwr_valid_o <= 1'b0;
      pwr_chan_o  <= '0;
      pwr_o       <= '0;
      for (int unsigned i = 0; i < NCHAN; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      pwr_valid_o <= 1'b0;
      if (clear_i) begin
        for (int unsigned i = 0; i < NCHAN; i++) begin
          acc[i] <= '0;
          cnt[i] <= '0;
        end
      end else if (tag_v[SQ_LATENCY]) begin
        cnt[ret_ch_c] <= cnt[ret_ch_c] + 1'b1;
        if (cnt[ret_ch_c] == CNT_W'(ACC_LEN - 1)) begin
          pwr_valid_o   <= 1'b1;
          pwr_chan_o    <= ret_ch_c;
          pwr_o         <= acc_sum_c;
          acc[ret_ch_c] <= '0;
        end else begin
          acc[ret_ch_c] <= acc_sum_c;
        end
      end
    end
  end

endmodule
